// File: rtl/gcd_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gcd_job_sequencer
// Purpose  : Feeds operand pairs to a subtractive GCD engine. It issues a
//            one-cycle go and waits for done. Zero operands are answered
//            directly, and a watchdog bounds how long a job may run.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_job_sequencer #(
    parameter int WIDTH   = 7,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    output logic             gcd_go,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_gcd,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] job_count
);

    // Last watchdog value still spent in WAIT; the job is aborted on it.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] ZERO_W  = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] watchdog;

    // Handshake flags and busy decode directly from state, so no input reaches an output combinationally.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == RESP);

    // Job sequencing: accept, launch, wait with watchdog, then respond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gcd_a     <= '0;
            gcd_b     <= '0;
            gcd_go    <= 1'b0;
            res_gcd   <= '0;
            res_err   <= 1'b0;
            watchdog  <= '0;
            job_count <= '0;
        end else begin
            // go is a single-cycle pulse unless re-armed below
            gcd_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        gcd_a <= in_a;
                        gcd_b <= in_b;
                        if (in_a == ZERO_W && in_b == ZERO_W) begin
                            // gcd(0,0) is undefined, so report it as an error
                            res_gcd <= '0;
                            res_err <= 1'b1;
                            state   <= RESP;
                        end else if (in_a == ZERO_W) begin
                            res_gcd <= in_b;
                            res_err <= 1'b0;
                            state   <= RESP;
                        end else if (in_b == ZERO_W) begin
                            res_gcd <= in_a;
                            res_err <= 1'b0;
                            state   <= RESP;
                        end else begin
                            // go is registered here so it is high during LAUNCH
                            gcd_go <= 1'b1;
                            state  <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    watchdog <= watchdog + CNT_ONE;
                    // A done that arrives on the last watchdog cycle still wins
                    if (gcd_done) begin
                        res_gcd <= gcd_out;
                        res_err <= 1'b0;
                        state   <= RESP;
                    end else if (watchdog == WD_LAST) begin
                        res_gcd <= '0;
                        res_err <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        job_count <= job_count + CNT_ONE;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_job_sequencer
// Purpose  : Directed checks of gcd_job_sequencer. Covers the engine path,
//            zero bypass, the watchdog, backpressure and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_job_sequencer;

    localparam int WIDTH   = 7;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic             gcd_go;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_gcd;
    logic             res_err;
    logic             busy;
    logic [CNT_W-1:0] job_count;

    int total = 0;
    int bad   = 0;
    int go_pulses = 0;

    gcd_job_sequencer #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .gcd_a    (gcd_a),
        .gcd_b    (gcd_b),
        .gcd_go   (gcd_go),
        .gcd_done (gcd_done),
        .gcd_out  (gcd_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_gcd  (res_gcd),
        .res_err  (res_err),
        .busy     (busy),
        .job_count(job_count)
    );

    always #5 clk = ~clk;

    // Count the cycles in which go is high, sampled mid-cycle
    always @(negedge clk) if (gcd_go) go_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept in RESP, then check the count and return to IDLE
    task automatic accept_result(input int exp_count);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 0);
        check("job_count", job_count, exp_count);
    endtask

    // Offer a pair for one cycle; the handshake happens on this tick
    task automatic send(input int a, input int b);
        in_valid = 1'b1;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int go_before;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        gcd_done = 1'b0; gcd_out = '0; res_ready = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_go", gcd_go, 0);
        check("rst_job_count", job_count, 0);
        check("rst_res_gcd", res_gcd, 0);
        check("rst_gcd_a", gcd_a, 0);
        @(negedge clk); rst = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 1);

        // done while idle is ignored
        gcd_done = 1'b1; gcd_out = 7'd99;
        tick();
        gcd_done = 1'b0;
        check("idle_done_ignored", busy, 0);

        // normal job (48,18) -> 6, done seen on the 5th wait cycle
        send(48, 18);
        check("launch_go", gcd_go, 1);
        check("launch_in_ready", in_ready, 0);
        check("launch_gcd_a", gcd_a, 48);
        check("launch_gcd_b", gcd_b, 18);
        tick();
        check("wait_go_low", gcd_go, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wait_no_valid", res_valid, 0);
        end
        gcd_done = 1'b1; gcd_out = 7'd6;
        tick();
        gcd_done = 1'b0; gcd_out = '0;
        check("job1_valid", res_valid, 1);
        check("job1_gcd", res_gcd, 6);
        check("job1_err", res_err, 0);
        check("job1_count_before", job_count, 0);
        accept_result(1);
        check("job1_go_pulses", go_pulses, 1);

        // zero bypass paths: no go should be issued
        go_before = go_pulses;
        send(0, 35);
        check("byp_a0_valid", res_valid, 1);
        check("byp_a0_gcd", res_gcd, 35);
        check("byp_a0_err", res_err, 0);
        accept_result(2);
        send(127, 0);
        check("byp_b0_valid", res_valid, 1);
        check("byp_b0_gcd", res_gcd, 127);
        check("byp_b0_err", res_err, 0);
        accept_result(3);
        send(0, 0);
        check("byp_00_valid", res_valid, 1);
        check("byp_00_gcd", res_gcd, 0);
        check("byp_00_err", res_err, 1);
        accept_result(4);
        check("byp_no_go", go_pulses, go_before);

        // watchdog: 8 wait cycles, then abort
        send(9, 6);
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            check("wd_still_wait", res_valid, 0);
        end
        tick();
        check("wd_valid", res_valid, 1);
        check("wd_err", res_err, 1);
        check("wd_gcd", res_gcd, 0);
        accept_result(5);

        // done on the final wait cycle beats the timeout
        send(9, 6);
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        gcd_done = 1'b1; gcd_out = 7'd3;
        tick();
        gcd_done = 1'b0; gcd_out = '0;
        check("wdpri_valid", res_valid, 1);
        check("wdpri_gcd", res_gcd, 3);
        check("wdpri_err", res_err, 0);
        accept_result(6);

        // backpressure, with a second pair waiting on the input
        send(20, 0);
        in_valid = 1'b1; in_a = 7'd0; in_b = 7'd9;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", res_valid, 1);
            check("bp_gcd", res_gcd, 20);
            check("bp_in_ready", in_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_count", job_count, 7);
        check("bp_idle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_second_valid", res_valid, 1);
        check("bp_second_gcd", res_gcd, 9);
        accept_result(8);

        // asynchronous reset while waiting on the engine
        go_before = go_pulses;
        send(9, 6);
        tick();
        tick();
        check("ar_busy_before", busy, 1);
        #3;
        rst = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_res_valid", res_valid, 0);
        check("ar_job_count", job_count, 0);
        check("ar_gcd_a", gcd_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            tick();
            check("ar_no_result", res_valid, 0);
        end
        check("ar_idle", busy, 0);
        check("ar_go_count", go_pulses, go_before + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
Upstream feeder for the GCD engine: accepts operand pairs over a valid/ready stream and holds them stable on the engine's operand inputs. It issues a one-cycle go, waits for done, captures the result, and presents it downstream with valid/ready. It also short-circuits zero operands and bounds engine run time with a watchdog, because the subtractive engine never terminates on a zero input.

Parameters:
WIDTH, 7, operand/result width; matches the engine data width
TIMEOUT, 255, max cycles in WAIT before aborting a job; must be >= 1
CNT_W, 8, width of the watchdog counter and the job counter; TIMEOUT must fit in CNT_W bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept a pair
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
gcd_a  output  WIDTH  to engine data_sel_1; registered, stable from LAUNCH until job end
gcd_b  output  WIDTH  to engine data_sel_2; registered, same stability rule
gcd_go  output  1  one-cycle start pulse to engine
gcd_done  input  1  engine completion, sampled as a level
gcd_out  input  WIDTH  engine result, valid while gcd_done=1
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_gcd  output  WIDTH  GCD result
res_err  output  1  job aborted by watchdog or both operands zero
busy  output  1  state != IDLE
job_count  output  CNT_W  completed jobs; increments on each res_valid&res_ready, wraps to 0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; gcd_a, gcd_b, res_gcd, watchdog and job_count = 0; gcd_go, res_valid, res_err, busy = 0; in_ready=1 once rst=1.
- States: IDLE, LAUNCH, WAIT, RESP. Encoding is free. All outputs are registered or decoded from state; there is no combinational in->out path.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_b into gcd_a/gcd_b.
  - If both operands != 0: go to LAUNCH.
  - If in_a=0, in_b!=0: go to RESP with res_gcd=in_b, res_err=0.
  - If in_b=0, in_a!=0: go to RESP with res_gcd=in_a, res_err=0.
  - If both are 0: go to RESP with res_gcd=0, res_err=1.
  - No gcd_go is issued on any bypass path.
- LAUNCH: gcd_go=1 for exactly this cycle; watchdog cleared; next state WAIT.
- WAIT: watchdog increments each cycle.
  - If gcd_done=1: capture gcd_out into res_gcd, res_err=0, go to RESP.
  - Else if watchdog reaches TIMEOUT-1: res_gcd=0, res_err=1, go to RESP.
  - gcd_done takes priority over timeout in the same cycle.
- RESP: res_valid=1; res_gcd and res_err held stable until accepted. On res_ready: job_count++, go to IDLE. res_valid falls the next cycle.
- in_ready=0 outside IDLE. Only one job is in flight; there is no overlap.
- Latency, handshake at edge N:
  - Engine path: gcd_go high during cycle N+1; WAIT from N+2; res_valid rises the cycle after gcd_done is first seen.
  - Bypass path: res_valid high at N+1.
- gcd_done asserted in IDLE, LAUNCH or RESP is ignored. Only WAIT samples it.
- Reset mid-job: all state is cleared immediately and no result is emitted. The engine's own state is the owner's concern; the system resets both together.
- gcd_a/gcd_b hold their last values after a job; they change only on a new accept.

Test Plan:
- Normal job: in (48,18) with an engine model returning 6 after 5 cycles -> exactly one gcd_go pulse one cycle after accept; res_gcd=6, res_err=0; job_count 0->1.
- Zero bypass: (0,35) -> res_valid one cycle after accept, res_gcd=35, gcd_go never asserted. Then (127,0) -> res_gcd=127.
- Both zero: (0,0) -> res_gcd=0, res_err=1, no gcd_go.
- Watchdog: TIMEOUT=8, engine stub never asserts done, input (9,6) -> RESP entered after 8 WAIT cycles with res_err=1, res_gcd=0. Then gcd_done=1 and gcd_out=3 arrive on the final WAIT cycle -> res_gcd=3, res_err=0 (done has priority).
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid and res_gcd stable, in_ready=0 throughout. A second pair held on in_valid is accepted only after the RESP handshake.
- Async reset in WAIT: assert rst=0 between clock edges -> busy=0 and res_valid=0 immediately, job_count=0, no spurious result after release.
